cpu_writeback: RTL and testbench

- Writer side of the CPU's 8x16 general-purpose register file; sole driver of its single write port (address, data, enable).
- Merges ALU results (same-cycle) and memory load returns (variable latency) onto that one port.
- Buffers colliding load returns in a small FIFO.
- Keeps a per-register pending-load scoreboard that decode uses to stall dependent instructions.

---
 rtl/cpu_wb_pkg.sv | 24 ++
 rtl/cpu_wb_fifo.sv | 42 ++++
 rtl/cpu_writeback.sv | 118 +++++++++++
 tb/tb_cpu_writeback.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_wb_pkg.sv
// Shared types and widths for the CPU register-file writeback path.
package cpu_wb_pkg;

  localparam int unsigned REG_W      = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_W-1:0]      data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LD_FIFO,
    WB_LD_BYPASS
  } wb_src_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    return NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/cpu_wb_fifo.sv
// Load-return FIFO: power-of-two depth, in-order, head read straight from storage.
module cpu_wb_fifo
  import cpu_wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_data,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Payload storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/cpu_writeback.sv
// Register-file write-port arbiter: merges ALU results and load returns, tracks pending loads.
module cpu_writeback
  import cpu_wb_pkg::*;
#(
  parameter int unsigned LD_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [REG_W-1:0]      i_alu_data,
  output logic                  o_alu_ready,
  input  logic                  i_ld_issue,
  input  logic [REG_ADDR_W-1:0] i_ld_issue_rd,
  input  logic                  i_ld_valid,
  input  logic [REG_ADDR_W-1:0] i_ld_rd,
  input  logic [REG_W-1:0]      i_ld_data,
  output logic                  o_ld_ready,
  output logic [REG_ADDR_W-1:0] o_rw,
  output logic                  o_rw_en,
  output logic [REG_W-1:0]      o_rw_data,
  output logic [NUM_REGS-1:0]   o_busy,
  output logic [2:0]            o_ld_count
);

  localparam int unsigned CNT_W = $clog2(LD_DEPTH) + 1;

  logic [CNT_W-1:0]    count;
  wb_entry_t           head;
  wb_entry_t           ld_entry;
  wb_entry_t           sel;
  wb_src_t             src;
  logic                fifo_full;
  logic                alu_xfer;
  logic                ld_xfer;
  logic                push;
  logic                pop;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_set;
  logic [NUM_REGS-1:0] busy_clr;

  cpu_wb_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (ld_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Both readies come from the registered count; a same-edge pop never frees a slot early.
  assign fifo_full   = (count == CNT_W'(LD_DEPTH));
  assign o_ld_ready  = (count < CNT_W'(LD_DEPTH));
  assign o_alu_ready = (count < CNT_W'(LD_DEPTH));
  assign alu_xfer    = i_alu_valid && o_alu_ready;
  assign ld_xfer     = i_ld_valid && o_ld_ready;
  assign ld_entry    = '{rd: i_ld_rd, data: i_ld_data};
  assign o_ld_count  = 3'(count);
  assign o_busy      = busy;

  // Write-port selection; a full FIFO stalls the ALU so buffered loads cannot starve.
  always_comb begin
    src  = WB_NONE;
    sel  = head;
    push = 1'b0;
    pop  = 1'b0;
    if (fifo_full) begin
      src = WB_LD_FIFO;
      pop = 1'b1;
    end else if (alu_xfer) begin
      src  = WB_ALU;
      sel  = '{rd: i_alu_rd, data: i_alu_data};
      push = ld_xfer;
    end else if (count != '0) begin
      src  = WB_LD_FIFO;
      pop  = 1'b1;
      push = ld_xfer;
    end else if (ld_xfer) begin
      src = WB_LD_BYPASS;
      sel = ld_entry;
    end
  end

  // Set is applied after clear so a same-edge set wins.
  always_comb begin
    busy_clr = '0;
    busy_set = '0;
    if (src == WB_LD_FIFO || src == WB_LD_BYPASS) busy_clr = reg_onehot(sel.rd);
    if (i_ld_issue) busy_set = reg_onehot(i_ld_issue_rd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rw      <= '0;
      o_rw_en   <= 1'b0;
      o_rw_data <= '0;
      busy      <= '0;
    end else begin
      o_rw_en <= (src != WB_NONE);
      if (src != WB_NONE) begin
        o_rw      <= sel.rd;
        o_rw_data <= sel.data;
      end
      busy <= (busy & ~busy_clr) | busy_set;
    end
  end

  // Decode-side hazard rules this block relies on but does not resolve.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(i_ld_issue && busy[i_ld_issue_rd]));
      assert (!(alu_xfer && busy[i_alu_rd]));
      assert (!(ld_xfer && !busy[i_ld_rd]));
    end
  end

endmodule

// File: tb/tb_cpu_writeback.sv
// Randomized bench for cpu_writeback against a queue-based model of the write-port rules.
module tb_cpu_writeback;
  import cpu_wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_alu_valid = 1'b0;
  logic [2:0]  i_alu_rd = '0;
  logic [15:0] i_alu_data = '0;
  logic        o_alu_ready;
  logic        i_ld_issue = 1'b0;
  logic [2:0]  i_ld_issue_rd = '0;
  logic        i_ld_valid = 1'b0;
  logic [2:0]  i_ld_rd = '0;
  logic [15:0] i_ld_data = '0;
  logic        o_ld_ready;
  logic [2:0]  o_rw;
  logic        o_rw_en;
  logic [15:0] o_rw_data;
  logic [7:0]  o_busy;
  logic [2:0]  o_ld_count;

  always #5 clk = ~clk;

  cpu_writeback #(.LD_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_alu_valid   (i_alu_valid),
    .i_alu_rd      (i_alu_rd),
    .i_alu_data    (i_alu_data),
    .o_alu_ready   (o_alu_ready),
    .i_ld_issue    (i_ld_issue),
    .i_ld_issue_rd (i_ld_issue_rd),
    .i_ld_valid    (i_ld_valid),
    .i_ld_rd       (i_ld_rd),
    .i_ld_data     (i_ld_data),
    .o_ld_ready    (o_ld_ready),
    .o_rw          (o_rw),
    .o_rw_en       (o_rw_en),
    .o_rw_data     (o_rw_data),
    .o_busy        (o_busy),
    .o_ld_count    (o_ld_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: buffered loads as {rd,data}, busy bits, loads issued but not yet returned.
  logic [18:0] q[$];
  logic [7:0]  m_busy;
  logic [7:0]  m_pend;
  logic [2:0]  m_rw;
  logic        m_en;
  logic [15:0] m_data;
  bit          alu_done;
  bit          ld_done;

  // Random-sender state (held until the transfer happens).
  logic        r_av;
  logic [2:0]  r_ard;
  logic [15:0] r_ad;
  logic        r_lv;
  logic [2:0]  r_lrd;
  logic [15:0] r_ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual 0x%0h required 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = '0;
    m_pend = '0;
    m_rw   = '0;
    m_en   = 1'b0;
    m_data = '0;
    alu_done = 1'b0;
    ld_done  = 1'b0;
  endtask

  task automatic model_write(input logic [2:0] rd, input logic [15:0] d, input bit is_ld);
    m_en   = 1'b1;
    m_rw   = rd;
    m_data = d;
    if (is_ld) m_busy[rd] = 1'b0;
  endtask

  task automatic model_edge(input logic av, input logic [2:0] ard, input logic [15:0] ad,
                            input logic iss, input logic [2:0] ird,
                            input logic lv, input logic [2:0] lrd, input logic [15:0] ldd);
    bit rdy;
    logic [18:0] e;
    rdy      = (q.size() < DEPTH);
    alu_done = av && rdy;
    ld_done  = lv && rdy;
    m_en     = 1'b0;
    if (!rdy) begin
      e = q.pop_front();
      model_write(e[18:16], e[15:0], 1'b1);
    end else if (alu_done) begin
      model_write(ard, ad, 1'b0);
      if (ld_done) q.push_back({lrd, ldd});
    end else if (q.size() > 0) begin
      e = q.pop_front();
      model_write(e[18:16], e[15:0], 1'b1);
      if (ld_done) q.push_back({lrd, ldd});
    end else if (ld_done) begin
      model_write(lrd, ldd, 1'b1);
    end
    if (ld_done) m_pend[lrd] = 1'b0;
    if (iss) begin
      m_busy[ird] = 1'b1;
      m_pend[ird] = 1'b1;
    end
  endtask

  // One clock: drive at the falling edge, check readiness before and outputs after the rising edge.
  task automatic step(input logic av, input logic [2:0] ard, input logic [15:0] ad,
                      input logic iss, input logic [2:0] ird,
                      input logic lv, input logic [2:0] lrd, input logic [15:0] ldd);
    i_alu_valid = av;  i_alu_rd = ard;  i_alu_data = ad;
    i_ld_issue  = iss; i_ld_issue_rd = ird;
    i_ld_valid  = lv;  i_ld_rd = lrd;   i_ld_data = ldd;
    #1;
    chk("ld_ready",  32'(o_ld_ready),  32'(q.size() < DEPTH));
    chk("alu_ready", 32'(o_alu_ready), 32'(q.size() < DEPTH));
    model_edge(av, ard, ad, iss, ird, lv, lrd, ldd);
    @(posedge clk);
    #1;
    chk("rw_en",    32'(o_rw_en),    32'(m_en));
    chk("rw",       32'(o_rw),       32'(m_rw));
    chk("rw_data",  32'(o_rw_data),  32'(m_data));
    chk("busy",     32'(o_busy),     32'(m_busy));
    chk("ld_count", 32'(o_ld_count), 32'(q.size()));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Raise reset between edges and check the outputs clear with no clock edge, then release.
  task automatic reset_mid(input string tag);
    #2;
    reset = 1'b1;
    i_alu_valid = 1'b0; i_ld_issue = 1'b0; i_ld_valid = 1'b0;
    #1;
    chk({tag, "_rst_rw_en"}, 32'(o_rw_en),    32'h0);
    chk({tag, "_rst_rw"},    32'(o_rw),       32'h0);
    chk({tag, "_rst_data"},  32'(o_rw_data),  32'h0);
    chk({tag, "_rst_busy"},  32'(o_busy),     32'h0);
    chk({tag, "_rst_count"}, 32'(o_ld_count), 32'h0);
    model_reset();
    r_av = 1'b0;
    r_lv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk({tag, "_rel_ld_ready"},  32'(o_ld_ready),  32'h1);
    chk({tag, "_rel_alu_ready"}, 32'(o_alu_ready), 32'h1);
  endtask

  function automatic int pick(input logic [7:0] mask);
    int cand[$];
    for (int r = 0; r < 8; r++) if (mask[r]) cand.push_back(r);
    if (cand.size() == 0) return -1;
    return cand[$urandom_range(cand.size() - 1)];
  endfunction

  task automatic rand_cycle();
    int   r;
    logic iss;
    logic [2:0] ird;
    if (!r_av || alu_done) begin
      r_av = 1'b0;
      if ($urandom_range(9) < 7) begin
        r = pick(~m_busy);
        if (r >= 0) begin
          r_av = 1'b1; r_ard = 3'(r); r_ad = 16'($urandom);
        end
      end
    end
    if (!r_lv || ld_done) begin
      r_lv = 1'b0;
      if ($urandom_range(9) < 5) begin
        r = pick(m_pend);
        if (r >= 0) begin
          r_lv = 1'b1; r_lrd = 3'(r); r_ld = 16'($urandom);
        end
      end
    end
    iss = 1'b0;
    ird = '0;
    if ($urandom_range(9) < 4) begin
      logic [7:0] m;
      m = ~m_busy;
      if (r_av) m[r_ard] = 1'b0;
      r = pick(m);
      if (r >= 0) begin
        iss = 1'b1; ird = 3'(r);
      end
    end
    step(r_av, r_ard, r_ad, iss, ird, r_lv, r_lrd, r_ld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    r_av = 1'b0;
    r_lv = 1'b0;

    // Asynchronous reset before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk("init_rw_en", 32'(o_rw_en),    32'h0);
    chk("init_rw",    32'(o_rw),       32'h0);
    chk("init_data",  32'(o_rw_data),  32'h0);
    chk("init_busy",  32'(o_busy),     32'h0);
    chk("init_count", 32'(o_ld_count), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("init_ld_ready",  32'(o_ld_ready),  32'h1);
    chk("init_alu_ready", 32'(o_alu_ready), 32'h1);

    // Plain ALU write, then idle.
    step(1, 3, 16'h1234, 0, 0, 0, 0, 0);
    chk("alu_rw_en", 32'(o_rw_en), 32'h1);
    chk("alu_rw",    32'(o_rw),    32'h3);
    chk("alu_data",  32'(o_rw_data), 32'h1234);
    idle(1);
    chk("alu_rw_en_off", 32'(o_rw_en), 32'h0);

    // Load issue then bypass return.
    step(0, 0, 0, 1, 5, 0, 0, 0);
    chk("issue5_busy", 32'(o_busy), 32'h20);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 5, 16'hBEEF);
    chk("byp_rw",    32'(o_rw),      32'h5);
    chk("byp_data",  32'(o_rw_data), 32'hBEEF);
    chk("byp_en",    32'(o_rw_en),   32'h1);
    chk("byp_busy",  32'(o_busy),    32'h00);

    // ALU and load collide: ALU first, load buffered then drained.
    step(0, 0, 0, 1, 2, 0, 0, 0);
    chk("issue2_busy", 32'(o_busy), 32'h04);
    step(1, 1, 16'h0001, 0, 0, 1, 2, 16'h0002);
    chk("col_rw",    32'(o_rw),       32'h1);
    chk("col_count", 32'(o_ld_count), 32'h1);
    idle(1);
    chk("col2_rw",    32'(o_rw),       32'h2);
    chk("col2_data",  32'(o_rw_data),  32'h0002);
    chk("col2_count", 32'(o_ld_count), 32'h0);
    chk("col2_busy",  32'(o_busy),     32'h00);

    // Fill the FIFO under continuous ALU traffic; the full FIFO must drain before the ALU resumes.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3'(4 + i), 0, 0, 0);
    chk("fill_busy", 32'(o_busy), 32'hF0);
    for (int i = 0; i < 4; i++) step(1, 0, 16'(16'h100 + i), 0, 0, 1, 3'(4 + i), 16'(16'hA0 + i));
    chk("full_count",     32'(o_ld_count),  32'h4);
    chk("full_ld_ready",  32'(o_ld_ready),  32'h0);
    chk("full_alu_ready", 32'(o_alu_ready), 32'h0);
    step(1, 0, 16'h0200, 0, 0, 0, 0, 0);
    chk("drain_rw",    32'(o_rw),       32'h4);
    chk("drain_data",  32'(o_rw_data),  32'h00A0);
    chk("drain_count", 32'(o_ld_count), 32'h3);
    step(1, 0, 16'h0200, 0, 0, 0, 0, 0);
    chk("resume_rw",   32'(o_rw),      32'h0);
    chk("resume_data", 32'(o_rw_data), 32'h0200);
    idle(3);
    chk("empty_busy",  32'(o_busy),     32'h00);
    chk("empty_count", 32'(o_ld_count), 32'h0);

    // Reset while loads are buffered: nothing may be written afterwards.
    step(0, 0, 0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0, 0, 0);
    step(1, 0, 16'h0011, 0, 0, 1, 2, 16'h0022);
    step(1, 1, 16'h0033, 0, 0, 1, 3, 16'h0044);
    chk("pre_flush_count", 32'(o_ld_count), 32'h2);
    chk("pre_flush_busy",  32'(o_busy),     32'h0C);
    reset_mid("flush");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("flush_no_write", 32'(o_rw_en), 32'h0);
    end

    // Random traffic with a mid-run reset.
    alu_done = 1'b0;
    ld_done  = 1'b0;
    for (int i = 0; i < 2000; i++) rand_cycle();
    reset_mid("rand");
    for (int i = 0; i < 500; i++) rand_cycle();
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
